// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor configuration controllers: sequencer
// FSM states, the datapath mode encoding and default sizing.
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [1:0] MODE_0 = 2'd0;
    localparam logic [1:0] MODE_1 = 2'd1;
    localparam logic [1:0] MODE_2 = 2'd2;
    localparam logic [1:0] MODE_3 = 2'd3;

    localparam int DEF_LEN_W      = 8;
    localparam int DEF_SETTLE_CYC = 2;

endpackage

// File: rtl/proc_settle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module proc_settle_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] count_r;

    assign expired = (count_r == {CNT_W{1'b0}});

    // Load has priority; counting stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && !expired) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/proc_job_sequencer.sv
// Job-level controller: applies a job's mode/bypass while the datapath is
// stalled, waits a settle window, then passes exactly the requested beats.
module proc_job_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_bypass,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              abort,
    output logic [1:0]        dp_mode,
    output logic              dp_bypass_en,
    input  logic              dp_valid,
    output logic              dp_ready,
    input  logic [DATA_W-1:0] dp_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  beat_cnt
);

    localparam bit HAS_SETTLE = (SETTLE_CYC > 0);
    localparam int TMR_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TMR_W-1:0] SETTLE_LOAD =
        HAS_SETTLE ? TMR_W'(SETTLE_CYC - 1) : {TMR_W{1'b0}};

    seq_state_e        state_r, state_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  beat_cnt_r;
    logic [1:0]        mode_r;
    logic              bypass_r;
    logic              aborted_r;
    logic              run_s, setup_s, accept_s, hs_s, last_s, tmr_expired_s;
    logic              abort_exit_s;

    assign run_s     = (state_r == ST_RUN);
    assign setup_s   = (state_r == ST_SETUP);
    assign cfg_ready = (state_r == ST_IDLE);
    assign accept_s  = cfg_valid & cfg_ready;

    // Beats flow only in RUN; elsewhere the datapath is held stalled.
    assign m_valid   = run_s & dp_valid;
    assign dp_ready  = run_s & m_ready;
    assign m_data    = dp_data;
    assign hs_s      = m_valid & m_ready;
    assign last_s    = (beat_cnt_r == (len_r - LEN_W'(1)));
    assign m_last    = m_valid & last_s;

    assign busy         = (state_r != ST_IDLE);
    assign done         = (state_r == ST_DONE);
    assign aborted      = aborted_r;
    assign beat_cnt     = beat_cnt_r;
    assign dp_mode      = mode_r;
    assign dp_bypass_en = bypass_r;

    // Completion of the final beat outranks a simultaneous abort.
    assign abort_exit_s = abort & (setup_s | (run_s & ~(hs_s & last_s)));

    proc_settle_timer #(
        .CNT_W (TMR_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val (SETTLE_LOAD),
        .en       (setup_s),
        .expired  (tmr_expired_s)
    );

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cfg_len == {LEN_W{1'b0}}) begin
                        state_s = ST_DONE;
                    end else if (HAS_SETTLE) begin
                        state_s = ST_SETUP;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (abort_exit_s || tmr_expired_s) begin
                    state_s = abort_exit_s ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_RUN: begin
                if ((hs_s && last_s) || abort_exit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register and job-completion flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            aborted_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_s == ST_DONE) begin
                aborted_r <= abort_exit_s;
            end else begin
                aborted_r <= aborted_r;
            end
        end
    end

    // Job descriptor capture and delivered-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r      <= {LEN_W{1'b0}};
            mode_r     <= 2'd0;
            bypass_r   <= 1'b0;
            beat_cnt_r <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            len_r      <= cfg_len;
            mode_r     <= cfg_mode;
            bypass_r   <= cfg_bypass;
            beat_cnt_r <= {LEN_W{1'b0}};
        end else if (hs_s) begin
            beat_cnt_r <= beat_cnt_r + LEN_W'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

endmodule

// File: tb/tb_proc_job_sequencer.sv
// Self-checking bench: directed job table, mid-job reset and random jobs
// checked against a job-level model of the sequencer.
module tb_proc_job_sequencer;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;
    localparam int S      = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid, cfg_ready, cfg_bypass, abort;
    logic [1:0]        cfg_mode, dp_mode;
    logic [LEN_W-1:0]  cfg_len, beat_cnt;
    logic              dp_bypass_en, dp_valid, dp_ready;
    logic [DATA_W-1:0] dp_data, m_data;
    logic              m_valid, m_ready, m_last, busy, done, aborted;

    int checks = 0;
    int errors = 0;
    logic [1:0] prev_mode = 2'd0;
    logic       prev_bp   = 1'b0;

    proc_job_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_bypass(cfg_bypass), .cfg_len(cfg_len),
        .abort(abort), .dp_mode(dp_mode), .dp_bypass_en(dp_bypass_en),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .aborted(aborted), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // pat: 0 random valid/ready with rare random abort, 1 always flowing,
    // 2 m_ready toggling. abort_at: beats delivered before abort (-1 none).
    task automatic do_job(input logic [1:0] md, input logic bp, input int len, input int pat,
                          input int abort_at, input bit abort_hs, input int gap);
        int  k, dlv;
        bit  ended, ab, run, v, r, a, hs;
        for (int g = 0; g < gap; g++) begin
            cfg_valid = 1'b0; abort = 1'($urandom_range(0, 1));
            dp_valid = 1'b1; m_ready = 1'b1;
            @(negedge clk);
            chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
            chk("idle_mode_hold", 32'(dp_mode), 32'(prev_mode));
            chk("idle_bp_hold", 32'(dp_bypass_en), 32'(prev_bp));
            chk("idle_m_valid", 32'(m_valid), 32'd0);
            @(posedge clk); #1;
        end
        cfg_valid = 1'b1; cfg_mode = md; cfg_bypass = bp; cfg_len = LEN_W'(len);
        abort = 1'b0; dp_valid = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        chk("acc_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("acc_mode_hold", 32'(dp_mode), 32'(prev_mode));
        chk("acc_dp_ready", 32'(dp_ready), 32'd0);
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_mode = 2'($urandom); cfg_bypass = 1'($urandom); cfg_len = LEN_W'($urandom);
        k = 1; dlv = 0; ended = (len == 0); ab = 1'b0;
        while (!ended && k < 3000) begin
            run = (k > S);
            case (pat)
                0:       begin v = ($urandom_range(0, 3) != 0); r = 1'($urandom); a = ($urandom_range(0, 31) == 0); end
                2:       begin v = 1'b1; r = 1'(k % 2); a = 1'b0; end
                default: begin v = 1'b1; r = 1'b1; a = 1'b0; end
            endcase
            if (run && abort_at >= 0 && dlv == abort_at) begin
                a = 1'b1; v = abort_hs; r = 1'b1;
            end
            dp_valid = v; m_ready = r; abort = a;
            @(negedge clk);
            hs = run && v && r;
            chk("run_m_valid", 32'(m_valid), 32'(run && v));
            chk("run_dp_ready", 32'(dp_ready), 32'(run && r));
            chk("run_m_last", 32'(m_last), 32'(run && v && (dlv == len - 1)));
            chk("run_busy_done", {30'd0, busy, done}, 32'd2);
            chk("run_mode", {29'd0, dp_mode, dp_bypass_en}, {29'd0, md, bp});
            if (hs) begin
                chk("run_m_data", 32'(m_data), 32'(dp_data));
                dlv++;
            end
            if (dlv == len) begin
                ended = 1'b1; ab = 1'b0;
            end else if (a) begin
                ended = 1'b1; ab = 1'b1;
            end
            @(posedge clk); #1;
            if (hs) dp_data = dp_data + 8'd1;
            k++;
        end
        if (!ended) chk("job_timeout", 32'd1, 32'd0);
        dp_valid = 1'b1; m_ready = 1'b1; abort = 1'($urandom);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_aborted", 32'(aborted), 32'(ab));
        chk("done_beat_cnt", 32'(beat_cnt), 32'(dlv));
        chk("done_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("done_gating", {30'd0, m_valid, dp_ready}, 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        prev_mode = md; prev_bp = bp;
    endtask

    typedef struct {
        logic [1:0] md; logic bp; int len; int pat; int abort_at; bit abort_hs;
        int gap; int exp_beats; bit exp_ab;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'd2, 1'b0, 4,   1, -1, 1'b0, 1, 4,   1'b0};  // basic
        vecs[1] = '{2'd1, 1'b1, 3,   2, -1, 1'b0, 0, 3,   1'b0};  // backpressure
        vecs[2] = '{2'd3, 1'b1, 0,   1, -1, 1'b0, 2, 0,   1'b0};  // zero length
        vecs[3] = '{2'd0, 1'b0, 255, 1, -1, 1'b0, 0, 255, 1'b0};  // max length
        vecs[4] = '{2'd2, 1'b1, 5,   1, 2,  1'b0, 1, 2,   1'b1};  // abort mid-job
        vecs[5] = '{2'd1, 1'b0, 5,   1, 4,  1'b1, 0, 5,   1'b0};  // abort on last beat
        vecs[6] = '{2'd1, 1'b1, 2,   1, -1, 1'b0, 1, 2,   1'b0};  // back-to-back A
        vecs[7] = '{2'd3, 1'b0, 2,   2, -1, 1'b0, 0, 2,   1'b0};  // back-to-back B

        rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd3; cfg_bypass = 1'b1; cfg_len = 8'd5;
        abort = 1'b0; dp_valid = 1'b1; m_ready = 1'b1; dp_data = 8'($urandom);
        #3;
        chk("rst_state", {25'd0, busy, cfg_ready, dp_ready, m_valid, done, aborted, dp_bypass_en},
            {25'd0, 7'b0100000});
        chk("rst_mode_cnt", {22'd0, dp_mode, beat_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_job(vecs[i].md, vecs[i].bp, vecs[i].len, vecs[i].pat, vecs[i].abort_at,
                   vecs[i].abort_hs, vecs[i].gap);
            chk("vec_beat_cnt", 32'(beat_cnt), 32'(vecs[i].exp_beats));
            chk("vec_aborted", 32'(aborted), 32'(vecs[i].exp_ab));
        end

        // Reset in the middle of RUN after three delivered beats.
        cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_bypass = 1'b1; cfg_len = 8'd6;
        dp_valid = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        repeat (S + 3) @(posedge clk);
        #1;
        chk("pre_rst_beat_cnt", 32'(beat_cnt), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy_rdy", {30'd0, busy, cfg_ready}, 32'd1);
        chk("midrst_gating", {29'd0, m_valid, dp_ready, done}, 32'd0);
        chk("midrst_cfg", {21'd0, dp_mode, dp_bypass_en, beat_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        prev_mode = 2'd0; prev_bp = 1'b0;

        for (int i = 0; i < 40; i++) begin
            do_job(2'($urandom), 1'($urandom), $urandom_range(0, 12), 0, -1, 1'b0,
                   $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_job_sequencer.md
Name: proc_job_sequencer

Overview:
- Job-level controller for the producer/processor datapath. It accepts one job descriptor at a time (mode, bypass, beat count), drives the datapath mode/bypass configuration, and gates the datapath's ready/valid so exactly the requested number of beats reaches downstream.
- Configuration changes happen only while the datapath is stalled, followed by a settle window, so no beat is ever processed with a half-applied mode.
- Sits between the datapath output and the downstream consumer.

Parameters:
- DATA_W, 8, width of the data beat.
- LEN_W, 8, width of the job length and beat counter.
- SETTLE_CYC, 2, stall cycles held after applying a new config before beats pass (0 allowed).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  descriptor accepted when cfg_valid & cfg_ready
- cfg_mode  in  2  processing mode for the job
- cfg_bypass  in  1  bypass enable for the job
- cfg_len  in  LEN_W  number of beats in the job
- abort  in  1  terminate the current job early
- dp_mode  out  2  to datapath mode
- dp_bypass_en  out  1  to datapath bypass_en
- dp_valid  in  1  datapath valid_out
- dp_ready  out  1  to datapath ready_out
- dp_data  in  DATA_W  datapath data_out
- m_valid  out  1  downstream valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_W  downstream data (= dp_data)
- m_last  out  1  final beat of the job
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job end
- aborted  out  1  registered; qualifies done: 1 = job ended by abort
- beat_cnt  out  LEN_W  beats delivered in the current/last job

Behaviour:
- Reset (async): state=IDLE, dp_mode=0, dp_bypass_en=0, beat_cnt=0, done=0, aborted=0. Consequently cfg_ready=1, dp_ready=0, m_valid=0.
- FSM states are IDLE, SETUP, RUN and DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid, latch len, load dp_mode and dp_bypass_en from cfg, and clear beat_cnt.
  - Next state: DONE if cfg_len==0; else SETUP if SETTLE_CYC>0; else RUN.
- SETUP: dp_ready=0 and m_valid=0 for exactly SETTLE_CYC cycles (settle counter), then RUN.
- RUN:
  - m_valid = dp_valid; dp_ready = m_ready; both combinational.
  - Each handshake (dp_valid & m_ready) increments beat_cnt.
  - m_last = m_valid & (beat_cnt == len-1).
  - On the handshake of the last beat, go to DONE.
- DONE: one cycle; done=1; cfg_ready=0; next state IDLE.
- Gating: outside RUN, dp_ready=0 and m_valid=0, so the datapath stalls and holds its data. m_data always mirrors dp_data.
- Latency: descriptor accepted at cycle N puts the FSM in RUN at cycle N+1+SETTLE_CYC. done is asserted the cycle after the last-beat handshake. The next descriptor can be accepted one cycle after done.
- dp_mode and dp_bypass_en change only on descriptor acceptance. They keep their values after the job ends and are never changed in RUN.
- Abort:
  - In SETUP or RUN: go to DONE next cycle with aborted=1. A beat handshaking in the same cycle is still delivered and counted.
  - Ignored in IDLE and DONE.
  - Abort on the last-beat cycle: completion wins, aborted=0.
- cfg_len==0: no beats pass, done pulses with beat_cnt=0 and aborted=0.
- Maximum length: cfg_len = 2^LEN_W-1. beat_cnt never wraps within a job.
- Reset mid-job: immediate return to IDLE with reset values. A partially transferred job is lost and done is not pulsed.
- aborted is updated on entry to DONE and holds until the next DONE.

Decomposition:
- Package proc_ctrl_pkg holds:
  - the FSM state enum (IDLE/SETUP/RUN/DONE);
  - the mode encoding constants shared with the processor (MODE_0..MODE_3);
  - default LEN_W and SETTLE_CYC.
- One natural sub-module, proc_settle_timer: a loadable down-counter that asserts expired. It is reusable by other config controllers. The FSM, beat counter and gating stay in the top.

Test Plan:
- Reset: assert rst mid-RUN with beat_cnt=3 -> outputs immediately take reset values, cfg_ready=1, no done pulse.
- Basic job: cfg_mode=2, cfg_bypass=0, cfg_len=4, SETTLE_CYC=2, m_ready=1 -> dp_mode=2 on cycle N+1, dp_ready low through N+2, 4 beats pass from N+3, m_last on the 4th beat, done one cycle later with beat_cnt=4 and aborted=0.
- Backpressure: cfg_len=3, toggle m_ready 1/0 every cycle -> dp_ready follows m_ready, exactly 3 beats counted, data order preserved, no beat lost or duplicated.
- Zero and maximum length: cfg_len=0 -> done 1 cycle after accept, no m_valid ever. cfg_len=255 -> 255 beats, beat_cnt=255, no wrap.
- Abort: abort in RUN after 2 of 5 beats -> done with aborted=1 and beat_cnt=2. Abort on the 5th-beat handshake -> beat_cnt=5, aborted=0.
- Back-to-back jobs: job A (mode 1, bypass 1, len 2) then job B (mode 3, bypass 0, len 2) queued on cfg -> dp_mode/dp_bypass_en change only on B's accept. No m_valid during B's SETUP. Config is stable throughout each RUN.
